// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch sequencer: drives the (unreset) PC register, the imem request
// channel and the IF/ID register, handling stall, branch redirect and wait states.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_cur_i,
  output logic [31:0] pc_next_o,
  output logic        pc_en_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc4_o,
  output logic        if_valid_o
);

  // state | meaning
  // BOOT  | load RESET_VECTOR into the PC, no request
  // REQ   | request outstanding at PC_CUR
  // HOLD  | fetched word parked in buffer while decode stalls
  // DRAIN | redirect pending; finish the unacked request first
  typedef enum logic [1:0] {BOOT = 2'd0, REQ = 2'd1, HOLD = 2'd2, DRAIN = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] pc_plus4;

  assign pc_plus4    = pc_cur_i + 32'd4;
  assign imem_addr_o = pc_cur_i;
  assign if_instr_o  = if_instr_q;
  assign if_pc4_o    = if_pc4_q;
  assign if_valid_o  = if_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= BOOT;
      if_instr_q  <= '0;
      if_pc4_q    <= '0;
      if_valid_q  <= 1'b0;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
      redir_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      if_instr_q  <= if_instr_d;
      if_pc4_q    <= if_pc4_d;
      if_valid_q  <= if_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      redir_pc_q  <= redir_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    if_instr_d  = if_instr_q;
    if_pc4_d    = if_pc4_q;
    if_valid_d  = if_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    redir_pc_d  = redir_pc_q;
    pc_en_o     = 1'b0;
    pc_next_o   = pc_plus4;
    imem_req_o  = 1'b0;

    unique case (state_q)
      BOOT: begin
        pc_en_o   = 1'b1;
        pc_next_o = RESET_VECTOR;
        state_d   = REQ;
      end
      REQ: begin
        imem_req_o = 1'b1;
        if (br_taken_i && imem_ack_i) begin
          pc_en_o    = 1'b1;
          pc_next_o  = br_target_i;
          if_valid_d = 1'b0;
        end else if (br_taken_i) begin
          // PC must not move until the pending request is acknowledged
          redir_pc_d = br_target_i;
          if_valid_d = 1'b0;
          state_d    = DRAIN;
        end else if (imem_ack_i && !stall_i) begin
          if_instr_d = imem_rdata_i;
          if_pc4_d   = pc_plus4;
          if_valid_d = 1'b1;
          pc_en_o    = 1'b1;
          pc_next_o  = pc_plus4;
        end else if (imem_ack_i) begin
          buf_instr_d = imem_rdata_i;
          buf_pc4_d   = pc_plus4;
          state_d     = HOLD;
        end else if (!stall_i) begin
          if_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (br_taken_i) begin
          pc_en_o    = 1'b1;
          pc_next_o  = br_target_i;
          if_valid_d = 1'b0;
          state_d    = REQ;
        end else if (!stall_i) begin
          if_instr_d = buf_instr_q;
          if_pc4_d   = buf_pc4_q;
          if_valid_d = 1'b1;
          pc_en_o    = 1'b1;
          pc_next_o  = buf_pc4_q;
          state_d    = REQ;
        end
      end
      DRAIN: begin
        imem_req_o = 1'b1;
        if (br_taken_i) redir_pc_d = br_target_i;
        if (imem_ack_i) begin
          pc_en_o   = 1'b1;
          pc_next_o = br_taken_i ? br_target_i : redir_pc_q;
          state_d   = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: models the PC register and a variable-latency imem;
// a scoreboard checks every instruction decode accepts, plus directed probes.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;

  int          n_checks;
  int          n_fail;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  int          mem_wait;
  int          mem_cnt;
  logic [31:0] sp_addr;
  logic [31:0] sp_data;
  logic        p_ok, p_req, p_ack;
  logic [31:0] p_addr;

  fetch_pc_ctrl #(.RESET_VECTOR(32'h0000_0040)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .pc_cur_i    (pc_cur),
    .pc_next_o   (pc_next),
    .pc_en_o     (pc_en),
    .imem_req_o  (imem_req),
    .imem_addr_o (imem_addr),
    .imem_ack_i  (imem_ack),
    .imem_rdata_i(imem_rdata),
    .stall_i     (stall),
    .br_taken_i  (br_taken),
    .br_target_i (br_target),
    .if_instr_o  (if_instr),
    .if_pc4_o    (if_pc4),
    .if_valid_o  (if_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The PC register under control: no reset, loads when enabled
  always @(posedge clk) if (pc_en) pc_cur <= pc_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    imem_ack = 1'b0; imem_rdata = '0; mem_wait = 0; mem_cnt = 0;
    sp_addr = 32'hFFFF_FFF0; sp_data = '0;
    p_ok = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_addr = '0;

    fork
      forever begin : memory
        @(posedge clk);
        #1;
        if (!rst_n || !imem_req) begin
          imem_ack = 1'b0;
          mem_cnt  = 0;
        end else if (mem_cnt == mem_wait) begin
          imem_ack   = 1'b1;
          imem_rdata = (imem_addr == sp_addr) ? sp_data : imem_addr;
          mem_cnt    = 0;
        end else begin
          imem_ack = 1'b0;
          mem_cnt++;
        end
      end
      forever begin : monitor
        @(negedge clk);
        if (rst_n) begin
          if (p_ok && p_req && !p_ack) begin
            chk1("req_held", imem_req, 1'b1);
            chk("addr_stable", imem_addr, p_addr);
          end
          // decode accepts a live instruction unless stalled or squashed
          if (if_valid && !stall && !br_taken) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_instr: got %h/%h expected none", if_instr, if_pc4);
            end else begin
              exp_e = exp_q.pop_front();
              chk("sb_instr", if_instr, exp_e[63:32]);
              chk("sb_pc4", if_pc4, exp_e[31:0]);
            end
          end
        end
        p_ok = rst_n; p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      end
    join_none

    // reset state
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_valid", if_valid, 1'b0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);
    chk1("rst_req", imem_req, 1'b0);
    chk1("boot_pc_en", pc_en, 1'b1);
    chk("boot_pc_next", pc_next, 32'h40);
    @(posedge clk);
    cyc();
    rst_n = 1'b1;
    #1;
    chk1("boot_req", imem_req, 1'b0);
    chk1("boot_pc_en2", pc_en, 1'b1);

    // zero-wait fetch
    exp_q.push_back({32'h40, 32'h44});
    exp_q.push_back({32'h44, 32'h48});
    exp_q.push_back({32'h48, 32'h4C});
    cyc(); #1;
    chk("zw_addr0", imem_addr, 32'h40);
    chk1("zw_req", imem_req, 1'b1);
    chk1("zw_pc_en", pc_en, 1'b1);
    chk("zw_pc_next", pc_next, 32'h44);
    cyc(); #1;
    chk1("zw_valid1", if_valid, 1'b1);
    chk("zw_instr", if_instr, 32'h40);
    chk("zw_pc4", if_pc4, 32'h44);
    chk("zw_addr1", imem_addr, 32'h44);
    cyc(); #1;
    chk1("zw_valid2", if_valid, 1'b1);
    chk("zw_addr2", imem_addr, 32'h48);
    mem_wait = 2;

    // two-wait memory
    exp_q.push_back({32'h4C, 32'h50});
    exp_q.push_back({32'h50, 32'h54});
    for (int k = 0; k < 6; k++) begin
      cyc(); #1;
      chk1("w2_valid", if_valid, (k % 3) == 0);
      chk1("w2_pc_en", pc_en, (k % 3) == 2);
      chk("w2_addr", imem_addr, 32'h4C + 32'(4 * (k / 3)));
    end
    sp_addr = 32'h54;
    sp_data = 32'hDEAD_BEEF;
    cyc(); #1;
    chk1("w2_valid6", if_valid, 1'b1);
    cyc(); #1;
    chk1("w2_valid7", if_valid, 1'b0);

    // stall into HOLD on the ack carrying DEAD_BEEF
    cyc();
    stall = 1'b1;
    exp_q.push_back({32'hDEAD_BEEF, 32'h58});
    #1;
    chk1("st_pc_en", pc_en, 1'b0);
    chk1("st_req", imem_req, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cyc(); #1;
      chk1("hold_req", imem_req, 1'b0);
      chk1("hold_pc_en", pc_en, 1'b0);
      chk("hold_instr", if_instr, 32'h50);
    end
    cyc();
    stall = 1'b0;
    #1;
    chk1("rel_pc_en", pc_en, 1'b1);
    chk("rel_pc_next", pc_next, 32'h58);
    cyc();
    mem_wait = 3;
    #1;
    chk("rel_instr", if_instr, 32'hDEAD_BEEF);
    chk("rel_pc4", if_pc4, 32'h58);
    chk1("rel_valid", if_valid, 1'b1);
    chk("rel_addr", imem_addr, 32'h58);

    // redirect during a wait, then a newer redirect before ack
    cyc();
    br_taken = 1'b1; br_target = 32'h1000;
    #1;
    chk1("rd_pc_en0", pc_en, 1'b0);
    chk1("rd_req0", imem_req, 1'b1);
    cyc();
    br_target = 32'h2000;
    #1;
    chk1("dr_req", imem_req, 1'b1);
    chk("dr_addr", imem_addr, 32'h58);
    chk1("dr_pc_en", pc_en, 1'b0);
    chk1("dr_valid", if_valid, 1'b0);
    cyc();
    br_taken = 1'b0;
    #1;
    chk1("dr_ack_pc_en", pc_en, 1'b1);
    chk("dr_ack_pc_next", pc_next, 32'h2000);
    chk1("dr_ack_valid", if_valid, 1'b0);
    mem_wait = 0;
    cyc(); #1;
    chk("rd_addr", imem_addr, 32'h2000);
    chk1("rd_valid", if_valid, 1'b0);

    // redirect over stall in HOLD, target wraps
    cyc();
    stall = 1'b1;
    #1;
    chk("rd_instr", if_instr, 32'h2000);
    chk("rd_pc4", if_pc4, 32'h2004);
    chk1("rd_valid2", if_valid, 1'b1);
    chk1("hs_pc_en0", pc_en, 1'b0);
    cyc();
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    #1;
    chk1("hs_req", imem_req, 1'b0);
    chk1("hs_pc_en", pc_en, 1'b1);
    chk("hs_pc_next", pc_next, 32'hFFFF_FFFC);
    cyc();
    br_taken = 1'b0; stall = 1'b0;
    sp_addr = 32'h0; sp_data = 32'hCAFE_F00D;
    exp_q.push_back({32'hFFFF_FFFC, 32'h0});
    #1;
    chk1("wr_valid0", if_valid, 1'b0);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    chk1("wr_pc_en", pc_en, 1'b1);
    chk("wr_pc_next", pc_next, 32'h0);
    cyc();
    mem_wait = 3;
    exp_q.push_back({32'hCAFE_F00D, 32'h4});
    #1;
    chk("wr_pc4", if_pc4, 32'h0);
    chk("wr_instr", if_instr, 32'hFFFF_FFFC);
    chk1("wr_valid", if_valid, 1'b1);
    chk("wr_addr0", imem_addr, 32'h0);

    // async reset while draining
    cyc(); #1;
    chk("ar_instr0", if_instr, 32'hCAFE_F00D);
    chk("ar_addr0", imem_addr, 32'h4);
    cyc();
    br_taken = 1'b1; br_target = 32'h3000;
    #1;
    chk1("ar_valid0", if_valid, 1'b0);
    cyc();
    br_taken = 1'b0;
    #1;
    chk1("ar_req_drain", imem_req, 1'b1);
    chk1("ar_pc_en_drain", pc_en, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("ar_valid", if_valid, 1'b0);
    chk("ar_instr", if_instr, 32'h0);
    chk("ar_pc4", if_pc4, 32'h0);
    chk1("ar_req", imem_req, 1'b0);
    chk1("ar_boot_pc_en", pc_en, 1'b1);
    chk("ar_boot_pc_next", pc_next, 32'h40);
    cyc(); #1;
    chk1("ar_req_held_low", imem_req, 1'b0);
    rst_n = 1'b1;
    cyc(); #1;
    chk1("rb_req", imem_req, 1'b1);
    chk("rb_addr", imem_addr, 32'h40);
    chk1("rb_pc_en", pc_en, 1'b0);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
